bus_cycle_arbiter: RTL

//  Owns the CPU external memory bus (addr_bus/data_bus/read_en/write_en/PSEN/memory_select).

---
 rtl/bus_cycle_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bus_cycle_arbiter.sv
// External memory bus owner: arbitrates instruction fetch vs MOVX data accesses
// and sequences each bus cycle, steering low code fetches to internal ROM when EA=1.
module bus_cycle_arbiter #(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [15:0] INT_ROM_TOP = 16'h0FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        EA,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   output logic [7:0]  if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [15:0] dm_addr,
   input  logic [7:0]  dm_wdata,
   output logic        dm_ack,
   output logic [7:0]  dm_rdata,
   output logic        rom_en,
   output logic [15:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic [15:0] addr_bus,
   inout  wire  [7:0]  data_bus,
   output logic        read_en,
   output logic        write_en,
   output logic        PSEN,
   output logic        memory_select,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_ACCESS = 3'd2,
      S_ROM    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic       GRANT_FETCH = 1'b0;
   localparam logic       GRANT_DATA  = 1'b1;
   localparam logic [3:0] WAIT_LAST   = 4'(WAIT_STATES);

   state_t      state;
   state_t      state_nx;
   logic        last_grant;
   logic        we_q;
   logic [7:0]  wdata_q;
   logic [3:0]  wait_cnt;
   logic        grant_fetch;
   logic        grant_data;
   logic        fetch_internal;
   logic        drive_bus;

   // Round-robin on contention: the side that did not win last time goes first
   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      if (if_req && dm_req) begin
         if (last_grant == GRANT_FETCH) grant_data  = 1'b1;
         else                           grant_fetch = 1'b1;
      end else if (if_req) begin
         grant_fetch = 1'b1;
      end else if (dm_req) begin
         grant_data = 1'b1;
      end
   end

   assign fetch_internal = EA && (if_addr <= INT_ROM_TOP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (grant_fetch)     state_nx = fetch_internal ? S_ROM : S_ADDR;
            else if (grant_data) state_nx = S_ADDR;
         end
         S_ADDR:   state_nx = S_ACCESS;
         S_ACCESS: if (wait_cnt == WAIT_LAST) state_nx = S_DONE;
         S_ROM:    if (wait_cnt == 4'd1) state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= GRANT_FETCH;
         we_q       <= 1'b0;
         wdata_q    <= 8'h00;
         wait_cnt   <= 4'd0;
         addr_bus   <= 16'h0000;
         rom_addr   <= 16'h0000;
         if_rdata   <= 8'h00;
         dm_rdata   <= 8'h00;
      end else begin
         if (state == S_IDLE) begin
            if (grant_data) begin
               last_grant <= GRANT_DATA;
               we_q       <= dm_we;
               wdata_q    <= dm_wdata;
               addr_bus   <= dm_addr;
            end else if (grant_fetch) begin
               last_grant <= GRANT_FETCH;
               we_q       <= 1'b0;
               if (fetch_internal) rom_addr <= if_addr;
               else                addr_bus <= if_addr;
            end
         end
         // Counter doubles as the ROM phase index and the ACCESS wait counter
         if ((state == S_ACCESS || state == S_ROM) && state_nx == state)
            wait_cnt <= wait_cnt + 4'd1;
         else
            wait_cnt <= 4'd0;
         if (state == S_ACCESS && wait_cnt == WAIT_LAST && !we_q) begin
            if (last_grant == GRANT_DATA) dm_rdata <= data_bus;
            else                          if_rdata <= data_bus;
         end
         if (state == S_ROM && wait_cnt == 4'd1)
            if_rdata <= rom_data;
      end
   end

   always_comb begin
      busy          = (state != S_IDLE);
      read_en       = 1'b0;
      write_en      = 1'b0;
      PSEN          = 1'b1;
      memory_select = 1'b0;
      rom_en        = 1'b0;
      if_ack        = 1'b0;
      dm_ack        = 1'b0;
      drive_bus     = 1'b0;
      case (state)
         S_ADDR: begin
            memory_select = last_grant;
            drive_bus     = (last_grant == GRANT_DATA) && we_q;
         end
         S_ACCESS: begin
            memory_select = last_grant;
            if (last_grant == GRANT_FETCH) begin
               read_en = 1'b1;
               PSEN    = 1'b0;
            end else if (we_q) begin
               write_en  = 1'b1;
               drive_bus = 1'b1;
            end else begin
               read_en = 1'b1;
            end
         end
         S_ROM: rom_en = (wait_cnt == 4'd0);
         S_DONE: begin
            memory_select = last_grant;
            if_ack        = (last_grant == GRANT_FETCH);
            dm_ack        = (last_grant == GRANT_DATA);
         end
         default: ;
      endcase
   end

   assign data_bus = drive_bus ? wdata_q : 8'bz;

   // Bus-protocol invariants
   a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(read_en && write_en));
   a_psen_fetch_only: assert property (@(posedge clk) disable iff (reset)
      !PSEN |-> (state == S_ACCESS && last_grant == GRANT_FETCH));

endmodule
